// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the instruction fetch front-end.
// Contents: XLEN, NOP encoding, fetch FSM state enum, queue entry struct.
// Imported by the fetch queue interface, top level and FIFO.
package cpu_pkg;

  localparam int XLEN = 32;

  // Bubble presented to decode when no instruction is available.
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // One queue slot: the instruction word and the address of the next sequential fetch.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: bundles the instruction-memory handshake and the decode-side signals.
// Ports: imem_req/imem_addr/imem_ack/imem_rdata (memory), redirect_valid/redirect_pc (branch),
//        stall, if_valid/if_instr/if_pc_plus4 (decode). slave = fetch queue, master = environment.
interface inst_fetch_queue_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc_plus4;

  modport slave (
    output imem_req, imem_addr, if_valid, if_instr, if_pc_plus4,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, stall
  );

  modport master (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc_plus4,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, stall
  );

endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// ifq_fifo: circular buffer of {instr, pc_plus4} entries, DEPTH a power of two.
// Ports: clk, rst (async, active-high), i_push/i_push_dat, i_pop, i_flush (clears everything),
//        o_head_dat (valid when !o_empty), o_count, o_full, o_empty.
module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  ifq_entry_t                 i_push_dat,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output ifq_entry_t                 o_head_dat,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifq_entry_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_push = i_push & (~o_full | i_pop);
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: nothing is read while the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch front-end feeding IF/ID; one outstanding imem request, DEPTH-entry queue.
// Ports: clk, rst (async, active-high), bus (inst_fetch_queue_if.slave: imem handshake, redirect, stall, decode outputs).
// Optional macro IFQ_BYPASS_EN: an ack into an empty queue is presented to decode in the same cycle.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  inst_fetch_queue_if.slave        bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_stale_addr;

  logic            w_req;
  logic            w_ack;
  logic            w_redirect;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_push;
  logic            w_pop;
  logic            w_bypass;
  logic [CW-1:0]   w_next_count;

  ifq_entry_t      w_push_dat;
  ifq_entry_t      w_head;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_full;
  logic            w_fifo_empty;

  assign w_req         = (r_state != IDLE);
  assign w_ack         = w_req & bus.imem_ack;
  assign w_redirect    = bus.redirect_valid;
  assign w_redirect_pc = bus.redirect_pc & ~32'h3;

  // Redirect overrides any pop; the flush empties the queue regardless.
  assign w_pop = ~w_fifo_empty & ~bus.stall & ~w_redirect;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_fifo_empty & (r_state == FETCH) & w_ack & ~w_redirect;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word that decode accepts right away never enters the queue.
  assign w_push = (r_state == FETCH) & w_ack & ~w_redirect & ~(w_bypass & ~bus.stall);

  assign w_push_dat.instr    = bus.imem_rdata;
  assign w_push_dat.pc_plus4 = r_fetch_pc + 32'd4;

  assign w_next_count = w_fifo_count + CW'(w_push) - CW'(w_pop);

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (w_redirect),
    .o_head_dat (w_head),
    .o_count    (w_fifo_count),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_redirect || (w_next_count < CW'(DEPTH))) w_state_nxt = FETCH;
      end
      FETCH: begin
        if (w_redirect) begin
          // The in-flight request now targets the old path; its data must be thrown away.
          w_state_nxt = w_ack ? FETCH : DISCARD;
        end else if (w_ack) begin
          w_state_nxt = (w_next_count < CW'(DEPTH)) ? FETCH : IDLE;
        end
      end
      DISCARD: begin
        // The stale request completing frees the port, even if another redirect lands now.
        if (w_ack) w_state_nxt = FETCH;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fetch_pc   <= RESET_PC;
      r_stale_addr <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (w_redirect) begin
        r_fetch_pc <= w_redirect_pc;
      end else if ((r_state == FETCH) && w_ack) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      // Keep presenting the abandoned address until memory answers it.
      if ((r_state == FETCH) && w_redirect && !w_ack) r_stale_addr <= r_fetch_pc;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = (r_state == DISCARD) ? r_stale_addr : r_fetch_pc;

  always_comb begin
    bus.if_valid    = 1'b0;
    bus.if_instr    = NOP;
    bus.if_pc_plus4 = '0;
    if (w_bypass) begin
      bus.if_valid    = 1'b1;
      bus.if_instr    = bus.imem_rdata;
      bus.if_pc_plus4 = r_fetch_pc + 32'd4;
    end else if (!w_fifo_empty) begin
      bus.if_valid    = 1'b1;
      bus.if_instr    = w_head.instr;
      bus.if_pc_plus4 = w_head.pc_plus4;
    end
  end

  logic w_unused;
  assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: randomized and directed stimulus against a queue-based reference model.
// Memory answers after a configurable or random latency with rdata = addr | 32'h2000_0000.
// Checks imem/decode outputs every cycle plus literal expectations for key scenarios.
module tb_inst_fetch_queue;
  import cpu_pkg::*;

  localparam int              DEPTH    = 4;
  localparam logic [31:0]     RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_queue_if ifc();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue contents, next fetch address, request-line expectation.
  ifq_entry_t  m_q[$];
  bit          m_req;
  bit          m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_stale;

  // Memory model.
  int          mem_cnt;
  int          mem_lat = 0;
  bit          mem_rand = 0;
  bit          force_en = 0;
  logic [31:0] force_val = 32'h0;

  // Snapshot of DUT outputs taken at the last negedge.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc4;
  bit          s_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_req   = 0;
    m_drop  = 0;
    m_pc    = RESET_PC;
    m_stale = RESET_PC;
    mem_cnt = mem_lat;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   ifc.imem_req,    0);
    check({tag, "_addr"},  ifc.imem_addr,   RESET_PC);
    check({tag, "_valid"}, ifc.if_valid,    0);
    check({tag, "_instr"}, ifc.if_instr,    32'h0);
    check({tag, "_pc4"},   ifc.if_pc_plus4, 32'h0);
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic cycle(input bit st, input bit rv, input logic [31:0] rpc);
    bit          ack, ack_m, byp, req_seen;
    logic [31:0] rdata;
    logic        e_valid;
    logic [31:0] e_instr, e_pc4;
    ifq_entry_t  e;

    req_seen = ifc.imem_req;
    ack      = req_seen && (mem_cnt == 0);
    rdata    = force_en ? force_val : (ifc.imem_addr | 32'h2000_0000);
    ifc.stall          = st;
    ifc.redirect_valid = rv;
    ifc.redirect_pc    = rpc;
    ifc.imem_ack       = ack;
    ifc.imem_rdata     = rdata;
    ack_m = m_req && ack;

    @(negedge clk);
    byp = 0;
`ifdef IFQ_BYPASS_EN
    byp = (m_q.size() == 0) && ack_m && !m_drop && !rv;
`endif
    if (byp) begin
      e_valid = 1; e_instr = rdata; e_pc4 = m_pc + 32'd4;
    end else if (m_q.size() > 0) begin
      e_valid = 1; e_instr = m_q[0].instr; e_pc4 = m_q[0].pc_plus4;
    end else begin
      e_valid = 0; e_instr = 32'h0; e_pc4 = 32'h0;
    end
    check("imem_req", ifc.imem_req, m_req);
    if (m_req) check("imem_addr", ifc.imem_addr, m_drop ? m_stale : m_pc);
    check("if_valid", ifc.if_valid, e_valid);
    check("if_instr", ifc.if_instr, e_instr);
    check("if_pc_plus4", ifc.if_pc_plus4, e_pc4);
    s_req = ifc.imem_req; s_addr = ifc.imem_addr; s_valid = ifc.if_valid;
    s_instr = ifc.if_instr; s_pc4 = ifc.if_pc_plus4; s_ack = ack;

    @(posedge clk);
    if (rv) begin
      m_q.delete();
      if (m_req && !ack) begin
        if (!m_drop) begin m_drop = 1; m_stale = m_pc; end
      end else begin
        m_drop = 0;
      end
      m_req = 1;
      m_pc  = rpc & ~32'h3;
    end else begin
      if (m_q.size() > 0 && !st) void'(m_q.pop_front());
      if (ack_m) begin
        if (m_drop) m_drop = 0;
        else begin
          if (!(byp && !st)) begin
            e.instr = rdata; e.pc_plus4 = m_pc + 32'd4;
            m_q.push_back(e);
          end
          m_pc = m_pc + 32'd4;
        end
      end
      if (!m_req || ack_m) m_req = (m_q.size() < DEPTH);
    end
    if (ack) mem_cnt = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
    else if (req_seen && mem_cnt > 0) mem_cnt--;
    #1;
  endtask

  task automatic run(input int n, input bit st);
    for (int i = 0; i < n; i++) cycle(st, 0, 32'h0);
  endtask

  // Reset pulse entirely between two clock edges; entered at posedge+1, left at posedge+4.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    ifc.imem_ack = 1'b0;
    ifc.redirect_valid = 1'b0;
    #2;
    check_reset_values(tag);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got[$];
    bit found;
    bit seen_new;

    rst = 1'b1;
    ifc.imem_ack = 0; ifc.imem_rdata = 0; ifc.redirect_valid = 0;
    ifc.redirect_pc = 0; ifc.stall = 0;
    model_reset();
    #3;
    check_reset_values("por");
    #13;
    rst = 1'b0;

    // A: single-cycle memory, no stall.
    cycle(0, 0, 0);
    check("a_idle_req", s_req, 0);
    cycle(0, 0, 0);
    check("a_first_req", s_req, 1);
    check("a_first_addr", s_addr, 32'h0);
`ifdef IFQ_BYPASS_EN
    check("a_byp_valid", s_valid, 1);
    check("a_byp_pc4", s_pc4, 32'h4);
    cycle(0, 0, 0);
    check("a_second_pc4", s_pc4, 32'h8);
`else
    check("a_first_valid", s_valid, 0);
    cycle(0, 0, 0);
    check("a_second_instr", s_instr, 32'h2000_0000);
    check("a_second_pc4", s_pc4, 32'h4);
`endif
    run(6, 0);

    // B: stall held while the queue fills, then drain in order.
    pulse_reset("b_rst");
    run(10, 1);
    check("b_full_req", s_req, 0);
    check("b_full_valid", s_valid, 1);
    got.delete();
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0);
      if (s_valid) got.push_back(s_instr);
    end
    check("b_delivered", (got.size() >= 8), 1);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check("b_order", got[i], 32'h2000_0000 + 32'(4 * i));

    // C: redirect while a slow request for 0x0C is outstanding.
    mem_lat = 3;
    pulse_reset("c_rst");
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ifc.imem_req && ifc.imem_addr == 32'hC && mem_cnt > 0) found = 1;
      else cycle(0, 0, 0);
    end
    check("c_found_0c", found, 1);
    cycle(0, 1, 32'h100);
    found = 0; seen_new = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(0, 0, 0);
      if (s_req && s_addr != 32'hC && !seen_new) begin
        seen_new = 1;
        check("c_new_addr", s_addr, 32'h100);
      end
      if (s_valid) begin
        found = 1;
        check("c_first_pc4", s_pc4, 32'h104);
      end
    end
    check("c_got_valid", found, 1);

    // D: redirect coinciding with an ack while decode stalls.
    mem_lat = 0;
    pulse_reset("d_rst");
    run(3, 1);
    cycle(1, 1, 32'h40);
    check("d_redir_ack", s_ack, 1);
    check("d_redir_valid", s_valid, 1);
    cycle(1, 0, 0);
    check("d_req", s_req, 1);
    check("d_addr", s_addr, 32'h40);
`ifdef IFQ_BYPASS_EN
    check("d_byp_pc4", s_pc4, 32'h44);
`else
    check("d_valid", s_valid, 0);
`endif

    // E: reset pulsed mid-request.
    mem_lat = 3;
    pulse_reset("e_pre");
    run(5, 0);
    pulse_reset("e_mid");
    cycle(0, 0, 0);
    check("e_idle_req", s_req, 0);
    cycle(0, 0, 0);
    check("e_restart_req", s_req, 1);
    check("e_restart_addr", s_addr, RESET_PC);

    // F: single ack into an empty queue.
    mem_lat = 4;
    force_en = 1; force_val = 32'h2002_0005;
    pulse_reset("f_rst");
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(0, 0, 0);
      if (s_ack) found = 1;
    end
    check("f_ack_seen", found, 1);
`ifdef IFQ_BYPASS_EN
    check("f_ack_cycle_valid", s_valid, 1);
    check("f_ack_cycle_instr", s_instr, 32'h2002_0005);
    cycle(0, 0, 0);
    check("f_next_valid", s_valid, 0);
`else
    check("f_ack_cycle_valid", s_valid, 0);
    cycle(0, 0, 0);
    check("f_next_valid", s_valid, 1);
    check("f_next_instr", s_instr, 32'h2002_0005);
    check("f_next_pc4", s_pc4, 32'h4);
`endif
    force_en = 0;

    // G: random stall, redirect (including near the top of the address space) and latency.
    mem_rand = 1; mem_lat = 1;
    pulse_reset("g_rst");
    for (int i = 0; i < 1500; i++) begin
      bit st, rv;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 99) < 5);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                         : ($urandom & 32'h0000_FFFF);
      if (i % 400 == 399) pulse_reset("g_mid");
      cycle(st, rv, rpc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
